instr_realign: RTL and testbench

- Sits between the I$ fetch response and the instruction queue.
- Converts one 32-bit fetch word per cycle into up to 2 aligned instructions (`INSTR_PER_FETCH`=2) and packs them into the queue's input slots.
- Handles RVC: holds the lower half of a 32-bit instruction that straddles a fetch boundary and merges it with the next fetch.
- Reports fetch exceptions as a single slot-0 entry.

---
 rtl/instr_realign_if.sv | 37 +++
 rtl/instr_realign.sv | 117 +++++++++++
 tb/tb_instr_realign.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/instr_realign_if.sv
// Fetch-side bus of the instruction realigner.
// Fetch half (frontend -> realigner):
//   valid_i                   fetch word valid this cycle
//   address_i                 byte address of the fetch (bit 1 set: entered mid-word)
//   data_i                    32-bit fetch word, little-endian halves
//   ex_i                      fetch carries a page fault; data_i is ignored
// Slot half (realigner -> instruction queue):
//   valid_o                   per-slot valid, packed from slot 0
//   instr_o                   slot instruction, compressed ones zero-extended
//   addr_o                    slot instruction address
//   ex_o                      slot 0 is an exception entry
//   serving_unaligned_o       a held lower half is pending
//   serving_unaligned_addr_o  address of the pending instruction
interface instr_realign_if #(
    parameter int unsigned INSTR_PER_FETCH = 2
);
    logic                                   valid_i;
    logic [63:0]                            address_i;
    logic [31:0]                            data_i;
    logic                                   ex_i;
    logic [INSTR_PER_FETCH-1:0]             valid_o;
    logic [INSTR_PER_FETCH-1:0][31:0]       instr_o;
    logic [INSTR_PER_FETCH-1:0][63:0]       addr_o;
    logic                                   ex_o;
    logic                                   serving_unaligned_o;
    logic [63:0]                            serving_unaligned_addr_o;

    modport master (
        output valid_i, address_i, data_i, ex_i,
        input  valid_o, instr_o, addr_o, ex_o, serving_unaligned_o, serving_unaligned_addr_o
    );

    modport slave (
        input  valid_i, address_i, data_i, ex_i,
        output valid_o, instr_o, addr_o, ex_o, serving_unaligned_o, serving_unaligned_addr_o
    );
endinterface

// File: rtl/instr_realign.sv
// Instruction realigner: splits one 32-bit fetch word per cycle into up to two aligned
// instructions (RVC aware), holding the lower half of a 32-bit instruction that straddles
// a fetch boundary and merging it with the next fetch. Fetch faults become a single
// slot-0 exception entry. All slot outputs are combinational.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   flush_i  discard any held half-instruction; gates outputs this cycle
//   fetch    fetch word in / instruction slots out (instr_realign_if.slave)
module instr_realign #(
    parameter int unsigned INSTR_PER_FETCH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    instr_realign_if.slave   fetch
);

    if (INSTR_PER_FETCH != 2) begin : g_bad_param
        $error("instr_realign: INSTR_PER_FETCH must be 2 for a 32-bit fetch");
    end

    logic        unaligned_q, unaligned_d;
    logic [15:0] held_q, held_d;
    logic [63:0] held_addr_q, held_addr_d;

    logic [15:0] lo, hi;
    logic        lo_c, hi_c;
    logic [63:0] hi_addr;
    logic        take_hi;

    assign lo   = fetch.data_i[15:0];
    assign hi   = fetch.data_i[31:16];
    assign lo_c = (lo[1:0] != 2'b11);
    assign hi_c = (hi[1:0] != 2'b11);
    // Upper half always sits at word base + 2; address_i bit 1 is irrelevant here.
    assign hi_addr = {fetch.address_i[63:2], 2'b10};

    assign fetch.serving_unaligned_o      = unaligned_q;
    assign fetch.serving_unaligned_addr_o = held_addr_q;

    always_comb begin
        unaligned_d   = unaligned_q;
        held_d        = held_q;
        held_addr_d   = held_addr_q;
        take_hi       = 1'b0;
        fetch.valid_o = '0;
        fetch.instr_o = '0;
        fetch.addr_o  = '0;
        fetch.ex_o    = 1'b0;

        if (fetch.valid_i && !flush_i && rst_ni) begin
            if (fetch.ex_i) begin
                fetch.valid_o[0] = 1'b1;
                fetch.ex_o       = 1'b1;
                fetch.addr_o[0]  = unaligned_q ? held_addr_q : fetch.address_i;
                unaligned_d      = 1'b0;
            end else if (unaligned_q) begin
                fetch.valid_o[0] = 1'b1;
                fetch.instr_o[0] = {lo, held_q};
                fetch.addr_o[0]  = held_addr_q;
                take_hi          = 1'b1;
            end else if (fetch.address_i[1]) begin
                // Entered mid-word: the lower half belongs to an earlier instruction.
                if (hi_c) begin
                    fetch.valid_o[0] = 1'b1;
                    fetch.instr_o[0] = {16'h0, hi};
                    fetch.addr_o[0]  = fetch.address_i;
                end else begin
                    held_d      = hi;
                    held_addr_d = fetch.address_i;
                    unaligned_d = 1'b1;
                end
            end else if (lo_c) begin
                fetch.valid_o[0] = 1'b1;
                fetch.instr_o[0] = {16'h0, lo};
                fetch.addr_o[0]  = fetch.address_i;
                take_hi          = 1'b1;
            end else begin
                fetch.valid_o[0] = 1'b1;
                fetch.instr_o[0] = fetch.data_i;
                fetch.addr_o[0]  = fetch.address_i;
                unaligned_d      = 1'b0;
            end

            if (take_hi) begin
                if (hi_c) begin
                    fetch.valid_o[1] = 1'b1;
                    fetch.instr_o[1] = {16'h0, hi};
                    fetch.addr_o[1]  = hi_addr;
                    unaligned_d      = 1'b0;
                end else begin
                    held_d      = hi;
                    held_addr_d = hi_addr;
                    unaligned_d = 1'b1;
                end
            end
        end

        if (flush_i) begin
            unaligned_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unaligned_q <= 1'b0;
            held_q      <= '0;
            held_addr_q <= '0;
        end else begin
            unaligned_q <= unaligned_d;
            held_q      <= held_d;
            held_addr_q <= held_addr_d;
        end
    end

endmodule

// File: tb/tb_instr_realign.sv
module tb_instr_realign;

    typedef struct {
        int          id;
        logic [1:0]  v;
        logic        ex;
        logic [31:0] i0;
        logic [63:0] a0;
        logic [31:0] i1;
        logic [63:0] a1;
        logic        su;
        logic [63:0] sua;
    } exp_t;

    localparam logic [63:0] WrapBase = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] WrapHi   = 64'hFFFF_FFFF_FFFF_FFFE;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;
    int   next_id;
    exp_t sb[$];
    exp_t mon_e;

    instr_realign_if #(.INSTR_PER_FETCH(2)) bus ();

    instr_realign #(.INSTR_PER_FETCH(2)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .fetch   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] v, input logic ex,
                                input logic [31:0] i0, input logic [63:0] a0,
                                input logic [31:0] i1, input logic [63:0] a1,
                                input logic su, input logic [63:0] sua);
        exp_t e;
        e.id = 0; e.v = v; e.ex = ex; e.i0 = i0; e.a0 = a0; e.i1 = i1; e.a1 = a1;
        e.su = su; e.sua = sua;
        return e;
    endfunction

    task automatic drive(input logic v, input logic fl, input logic ex,
                         input logic [63:0] a, input logic [31:0] d, input exp_t e);
        exp_t t;
        @(posedge clk);
        #1;
        bus.valid_i   = v;
        flush         = fl;
        bus.ex_i      = ex;
        bus.address_i = a;
        bus.data_i    = d;
        t    = e;
        t.id = next_id;
        next_id++;
        sb.push_back(t);
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check($sformatf("v%0d valid_o", mon_e.id), 64'(bus.valid_o), 64'(mon_e.v));
            check($sformatf("v%0d ex_o", mon_e.id), 64'(bus.ex_o), 64'(mon_e.ex));
            check($sformatf("v%0d instr0", mon_e.id), 64'(bus.instr_o[0]), 64'(mon_e.i0));
            check($sformatf("v%0d addr0", mon_e.id), bus.addr_o[0], mon_e.a0);
            check($sformatf("v%0d instr1", mon_e.id), 64'(bus.instr_o[1]), 64'(mon_e.i1));
            check($sformatf("v%0d addr1", mon_e.id), bus.addr_o[1], mon_e.a1);
            check($sformatf("v%0d serving", mon_e.id), 64'(bus.serving_unaligned_o),
                  64'(mon_e.su));
            check($sformatf("v%0d serving_addr", mon_e.id), bus.serving_unaligned_addr_o,
                  mon_e.sua);
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        next_id = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        bus.valid_i   = 1'b1;
        bus.ex_i      = 1'b0;
        bus.address_i = 64'h1000;
        bus.data_i    = 32'h4585_4501;
        #3;
        check("reset valid_o", 64'(bus.valid_o), 64'd0);
        check("reset ex_o", 64'(bus.ex_o), 64'd0);
        check("reset serving", 64'(bus.serving_unaligned_o), 64'd0);
        check("reset serving_addr", bus.serving_unaligned_addr_o, 64'd0);
        bus.valid_i = 1'b0;
        #4;
        rst_n = 1'b1;

        // Aligned RVC pair
        drive(1, 0, 0, 64'h1000, 32'h4585_4501,
              mk(2'b11, 0, 32'h4501, 64'h1000, 32'h4585, 64'h1002, 0, 64'h0));
        // Straddle: hold upper half, then merge
        drive(1, 0, 0, 64'h2000, 32'h0513_4501,
              mk(2'b01, 0, 32'h4501, 64'h2000, 32'h0, 64'h0, 0, 64'h0));
        drive(1, 0, 0, 64'h2004, 32'h4505_0000,
              mk(2'b11, 0, 32'h0000_0513, 64'h2002, 32'h4505, 64'h2006, 1, 64'h2002));
        // Mid-word entry: compressed upper, then 32-bit upper held
        drive(1, 0, 0, 64'h3002, 32'h4581_FFFF,
              mk(2'b01, 0, 32'h4581, 64'h3002, 32'h0, 64'h0, 0, 64'h2002));
        drive(1, 0, 0, 64'h3002, 32'h0513_FFFF,
              mk(2'b00, 0, 32'h0, 64'h0, 32'h0, 64'h0, 0, 64'h2002));
        drive(0, 0, 0, 64'h3004, 32'h0,
              mk(2'b00, 0, 32'h0, 64'h0, 32'h0, 64'h0, 1, 64'h3002));
        // Flush during hold, then a fresh 32-bit fetch with no merge
        drive(1, 1, 0, 64'h4000, 32'h0000_0513,
              mk(2'b00, 0, 32'h0, 64'h0, 32'h0, 64'h0, 1, 64'h3002));
        drive(1, 0, 0, 64'h4000, 32'h0000_0513,
              mk(2'b01, 0, 32'h0000_0513, 64'h4000, 32'h0, 64'h0, 0, 64'h3002));
        // Exception while holding a half at 0x5002
        drive(1, 0, 0, 64'h5000, 32'h0513_4501,
              mk(2'b01, 0, 32'h4501, 64'h5000, 32'h0, 64'h0, 0, 64'h3002));
        drive(1, 0, 1, 64'h5004, 32'hDEAD_BEEF,
              mk(2'b01, 1, 32'h0, 64'h5002, 32'h0, 64'h0, 1, 64'h5002));
        drive(0, 0, 0, 64'h5008, 32'h0,
              mk(2'b00, 0, 32'h0, 64'h0, 32'h0, 64'h0, 0, 64'h5002));
        // Top of address space
        drive(1, 0, 0, WrapBase, 32'h4585_4501,
              mk(2'b11, 0, 32'h4501, WrapBase, 32'h4585, WrapHi, 0, 64'h5002));
        drive(1, 0, 0, WrapBase, 32'h0513_4501,
              mk(2'b01, 0, 32'h4501, WrapBase, 32'h0, 64'h0, 0, 64'h5002));
        drive(0, 0, 0, 64'h0, 32'h0,
              mk(2'b00, 0, 32'h0, 64'h0, 32'h0, 64'h0, 1, WrapHi));

        // Asynchronous reset mid-cycle while a half is held
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async serving", 64'(bus.serving_unaligned_o), 64'd0);
        check("async serving_addr", bus.serving_unaligned_addr_o, 64'd0);
        bus.valid_i   = 1'b1;
        bus.address_i = 64'h6000;
        bus.data_i    = 32'h4585_4501;
        #0.5;
        check("async valid_o gated", 64'(bus.valid_o), 64'd0);
        bus.valid_i = 1'b0;
        #0.5;
        rst_n = 1'b1;

        // First fetch after reset is fresh, not merged
        drive(1, 0, 0, 64'h6000, 32'h0000_0513,
              mk(2'b01, 0, 32'h0000_0513, 64'h6000, 32'h0, 64'h0, 0, 64'h0));
        drive(0, 0, 0, 64'h6004, 32'h0,
              mk(2'b00, 0, 32'h0, 64'h0, 32'h0, 64'h0, 0, 64'h0));

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
